// File: rtl/perf_pkg.sv
// Shared types and constants for the retirement performance monitor.
// Select codes, readback magic and default sizing.
package perf_pkg;

    localparam int          PERF_CNT_W       = 32;
    localparam int          PERF_TRACE_DEPTH = 8;
    localparam logic [31:0] PERF_MAGIC       = 32'h5045_5246;

    typedef enum logic [2:0] {
        SEL_CYC   = 3'd0,
        SEL_RET   = 3'd1,
        SEL_CTL   = 3'd2,
        SEL_MIS   = 3'd3,
        SEL_BUB   = 3'd4,
        SEL_PC    = 3'd5,
        SEL_TRACE = 3'd6,
        SEL_MAGIC = 3'd7
    } perf_sel_e;

endpackage

// File: rtl/perf_trace_fifo.sv
// Synchronous first-word-fall-through FIFO for mispredict PCs.
// Pointers carry a wrap bit; a push at full is taken only alongside a pop.
module perf_trace_fifo
    import perf_pkg::*;
#(
    parameter int DEPTH = PERF_TRACE_DEPTH,
    parameter int W     = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_data,
    output logic [W-1:0]  o_data,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_cnt
);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_cnt   = wr_ptr_q - rd_ptr_q;
    assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Accept/advance decisions and next pointer values.
    always_comb begin
        do_pop   = i_pop & ~o_empty;
        do_push  = i_push & (~o_full | do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // Pointer registers; reset empties the FIFO at once.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents past the pointers are don't-care.
    always_ff @(posedge i_clk) begin
        if (do_push && !i_clear) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/pipe_perf_monitor.sv
// Commit-side event counters, last retired PC and mispredict trace.
// All results leave through a one-cycle registered readback mux.
module pipe_perf_monitor
    import perf_pkg::*;
#(
    parameter int CNT_W       = PERF_CNT_W,
    parameter int TRACE_DEPTH = PERF_TRACE_DEPTH,
    parameter int CW          = $clog2(TRACE_DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_insn_vld,
    input  logic          i_ctrl,
    input  logic          i_mispred,
    input  logic [31:0]   i_pc_debug,
    input  logic          i_clear,
    input  logic          i_freeze,
    input  logic [2:0]    i_sel,
    output logic [31:0]   o_rd_data,
    input  logic          i_trace_rd,
    output logic          o_trace_vld,
    output logic [31:0]   o_trace_pc,
    output logic [CW-1:0] o_trace_cnt,
    output logic          o_trace_ovf
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic [CNT_W-1:0] ctl_q, ctl_d;
    logic [CNT_W-1:0] mis_q, mis_d;
    logic [CNT_W-1:0] bub_q, bub_d;
    logic [31:0]      last_pc_q, last_pc_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      rd_data_q, rd_data_d;

    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;

    assign push = i_insn_vld & i_mispred & ~i_freeze & ~i_clear;
    assign pop  = i_trace_rd & ~i_clear;

    perf_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .W     (32),
        .AW    (CW - 1)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (i_clear),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  (i_pc_debug),
        .o_data  (o_trace_pc),
        .o_empty (fifo_empty),
        .o_full  (fifo_full),
        .o_cnt   (o_trace_cnt)
    );

    assign o_trace_vld = ~fifo_empty;
    assign o_trace_ovf = ovf_q;
    assign o_rd_data   = rd_data_q;

    // Event counters and last PC: clear beats freeze beats counting.
    always_comb begin
        cyc_d     = cyc_q;
        ret_d     = ret_q;
        ctl_d     = ctl_q;
        mis_d     = mis_q;
        bub_d     = bub_q;
        last_pc_d = last_pc_q;
        if (i_clear) begin
            cyc_d     = '0;
            ret_d     = '0;
            ctl_d     = '0;
            mis_d     = '0;
            bub_d     = '0;
            last_pc_d = '0;
        end else if (!i_freeze) begin
            cyc_d = cyc_q + ONE;
            if (i_insn_vld) begin
                ret_d     = ret_q + ONE;
                last_pc_d = i_pc_debug;
                if (i_ctrl)    ctl_d = ctl_q + ONE;
                if (i_mispred) mis_d = mis_q + ONE;
            end else begin
                bub_d = bub_q + ONE;
            end
        end
    end

    // Sticky overflow: a push refused because full with no pop.
    always_comb begin
        ovf_d = ovf_q;
        if (i_clear) begin
            ovf_d = 1'b0;
        end else if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // Readback source select from pre-edge state.
    always_comb begin
        rd_data_d = '0;
        unique case (perf_sel_e'(i_sel))
            SEL_CYC:   rd_data_d = 32'(cyc_q);
            SEL_RET:   rd_data_d = 32'(ret_q);
            SEL_CTL:   rd_data_d = 32'(ctl_q);
            SEL_MIS:   rd_data_d = 32'(mis_q);
            SEL_BUB:   rd_data_d = 32'(bub_q);
            SEL_PC:    rd_data_d = last_pc_q;
            SEL_TRACE: begin
                rd_data_d     = 32'(o_trace_cnt);
                rd_data_d[31] = ovf_q;
            end
            SEL_MAGIC: rd_data_d = PERF_MAGIC;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cyc_q     <= '0;
            ret_q     <= '0;
            ctl_q     <= '0;
            mis_q     <= '0;
            bub_q     <= '0;
            last_pc_q <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            cyc_q     <= cyc_d;
            ret_q     <= ret_d;
            ctl_q     <= ctl_d;
            mis_q     <= mis_d;
            bub_q     <= bub_d;
            last_pc_q <= last_pc_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor (CNT_W=8, TRACE_DEPTH=8).
// Expected values are hand-derived constants per scenario.
module tb_pipe_perf_monitor;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          insn_vld;
    logic          ctrl;
    logic          mispred;
    logic [31:0]   pc;
    logic          clear;
    logic          freeze;
    logic [2:0]    sel;
    logic [31:0]   rd_data;
    logic          trace_rd;
    logic          trace_vld;
    logic [31:0]   trace_pc;
    logic [CW-1:0] trace_cnt;
    logic          trace_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_perf_monitor #(
        .CNT_W       (8),
        .TRACE_DEPTH (8)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_insn_vld  (insn_vld),
        .i_ctrl      (ctrl),
        .i_mispred   (mispred),
        .i_pc_debug  (pc),
        .i_clear     (clear),
        .i_freeze    (freeze),
        .i_sel       (sel),
        .o_rd_data   (rd_data),
        .i_trace_rd  (trace_rd),
        .o_trace_vld (trace_vld),
        .o_trace_pc  (trace_pc),
        .o_trace_cnt (trace_cnt),
        .o_trace_ovf (trace_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        insn_vld = 0; ctrl = 0; mispred = 0;
        clear = 0; trace_rd = 0;
    endtask

    task automatic retire(input logic c, input logic m,
                          input logic [31:0] p);
        insn_vld = 1; ctrl = c; mispred = m; pc = p;
        step();
        idle();
    endtask

    task automatic do_clear();
        clear = 1;
        step();
        clear = 0;
    endtask

    initial begin
        rst_n = 0; idle(); pc = '0; freeze = 0; sel = 3'd0;
        step(); step();
        chk("rst_rd", rd_data, 32'h0);
        chk("rst_vld", {31'b0, trace_vld}, 32'h0);
        chk("rst_pc", trace_pc, 32'h0);
        chk("rst_cnt", 32'(trace_cnt), 32'h0);
        chk("rst_ovf", {31'b0, trace_ovf}, 32'h0);

        rst_n = 1; sel = 3'd4;
        for (int i = 0; i < 10; i++) step();
        chk("idle_bub", rd_data, 32'd9);
        chk("idle_vld", {31'b0, trace_vld}, 32'h0);
        chk("idle_tpc", trace_pc, 32'h0);
        chk("idle_cnt", 32'(trace_cnt), 32'h0);

        do_clear();
        retire(0, 0, 32'h30);
        retire(1, 0, 32'h34);
        retire(1, 1, 32'h40);
        retire(0, 0, 32'h44);
        retire(0, 0, 32'h48);
        sel = 3'd1; step(); chk("ret", rd_data, 32'd5);
        sel = 3'd2; step(); chk("ctl", rd_data, 32'd2);
        sel = 3'd3; step(); chk("mis", rd_data, 32'd1);
        sel = 3'd5; step(); chk("last_pc", rd_data, 32'h48);
        sel = 3'd0; step(); chk("cyc", rd_data, 32'd9);
        chk("ret_vld", {31'b0, trace_vld}, 32'h1);
        chk("ret_tpc", trace_pc, 32'h40);
        chk("ret_cnt", 32'(trace_cnt), 32'h1);

        do_clear();
        for (int i = 0; i < 9; i++) retire(0, 1, 32'h100 + 32'(4 * i));
        chk("full_cnt", 32'(trace_cnt), 32'd8);
        chk("full_ovf", {31'b0, trace_ovf}, 32'h1);
        chk("full_head", trace_pc, 32'h100);
        sel = 3'd6; step();
        chk("sel6", rd_data, 32'h8000_0008);
        trace_rd = 1;
        retire(0, 1, 32'h200);
        chk("pp_cnt", 32'(trace_cnt), 32'd8);
        chk("pp_head", trace_pc, 32'h104);
        trace_rd = 1;
        for (int i = 0; i < 7; i++) step();
        trace_rd = 0;
        chk("pp_tail", trace_pc, 32'h200);
        chk("pp_cnt1", 32'(trace_cnt), 32'd1);

        freeze = 1; sel = 3'd0;
        for (int i = 0; i < 4; i++) begin
            insn_vld = 1; mispred = 1; ctrl = 1;
            pc = 32'h300 + 32'(4 * i);
            step();
        end
        idle();
        chk("frz_cyc", rd_data, 32'd18);
        chk("frz_cnt", 32'(trace_cnt), 32'd1);
        chk("frz_head", trace_pc, 32'h200);
        sel = 3'd3; step(); chk("frz_mis", rd_data, 32'd10);
        sel = 3'd5; step(); chk("frz_pc", rd_data, 32'h200);
        trace_rd = 1; step(); trace_rd = 0;
        chk("frz_pop_cnt", 32'(trace_cnt), 32'd0);
        chk("frz_pop_vld", {31'b0, trace_vld}, 32'h0);
        freeze = 0;

        retire(0, 1, 32'h400);
        chk("pre_rst_vld", {31'b0, trace_vld}, 32'h1);
        rst_n = 0; step();
        chk("rst2_vld", {31'b0, trace_vld}, 32'h0);
        chk("rst2_cnt", 32'(trace_cnt), 32'h0);
        chk("rst2_ovf", {31'b0, trace_ovf}, 32'h0);
        rst_n = 1; sel = 3'd0;
        for (int i = 0; i < 256; i++) step();
        chk("wrap_255", rd_data, 32'd255);
        step();
        chk("wrap_0", rd_data, 32'd0);

        for (int i = 0; i < 9; i++) retire(0, 1, 32'h500 + 32'(4 * i));
        chk("pre_clr_ovf", {31'b0, trace_ovf}, 32'h1);
        sel = 3'd3; clear = 1; insn_vld = 1; mispred = 1; pc = 32'h600;
        step();
        idle();
        chk("clr_rd_pre", rd_data, 32'd9);
        chk("clr_cnt", 32'(trace_cnt), 32'd0);
        chk("clr_vld", {31'b0, trace_vld}, 32'h0);
        chk("clr_ovf", {31'b0, trace_ovf}, 32'h0);
        step(); chk("clr_mis", rd_data, 32'd0);
        sel = 3'd1; step(); chk("clr_ret", rd_data, 32'd0);
        sel = 3'd0; step(); chk("clr_cyc", rd_data, 32'd2);

        sel = 3'd7; step(); chk("magic", rd_data, 32'h5045_5246);
        trace_rd = 1; step(); trace_rd = 0;
        chk("pop_empty_cnt", 32'(trace_cnt), 32'd0);
        chk("pop_empty_vld", {31'b0, trace_vld}, 32'h0);
        retire(0, 1, 32'h700);
        chk("post_pop_cnt", 32'(trace_cnt), 32'd1);
        chk("post_pop_head", trace_pc, 32'h700);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
